// File: rtl/sp_link_controller.sv
// Link-level sequencer for the receiver's parallel byte stream: tracks sync,
// strips idle symbols, flags loss of sync / data gaps and requests resync.
module sp_link_controller #(
  parameter logic [7:0]  IDLE_SYM    = 8'hBC,
  parameter int unsigned SYNC_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned MAX_GAP     = 16
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       active,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       link_up,
  output logic [2:0] state,
  output logic       err,
  output logic [7:0] err_count,
  output logic       resync
);

  localparam int unsigned SYNC_W = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
  localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W  = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_IDLE  = 3'd2,
    S_DATA  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t             cur_state, next_state;
  logic [SYNC_W-1:0]  sync_cnt, sync_next;
  logic [TMO_W-1:0]   tmo_cnt, tmo_next;
  logic [GAP_W-1:0]   gap_cnt, gap_next;
  logic               resync_next;
  logic               fwd_c;

  assign state = cur_state;

  // Counters are only live in their own state; every transition clears them.
  always_comb begin
    next_state  = cur_state;
    sync_next   = '0;
    tmo_next    = '0;
    gap_next    = '0;
    resync_next = 1'b0;
    fwd_c       = ((cur_state == S_IDLE) || (cur_state == S_DATA)) &&
                  active && valid_in && (data_in != IDLE_SYM);
    case (cur_state)
      S_RESET: next_state = S_WAIT;
      S_WAIT: begin
        if (active && (sync_cnt == SYNC_W'(SYNC_CYCLES - 1))) begin
          next_state = S_IDLE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          resync_next = 1'b1;
        end else begin
          tmo_next  = tmo_cnt + TMO_W'(1);
          sync_next = active ? (sync_cnt + SYNC_W'(1)) : '0;
        end
      end
      S_IDLE: begin
        if (!active) begin
          next_state = S_ERROR;
        end else if (valid_in && (data_in != IDLE_SYM)) begin
          next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (!active) begin
          next_state = S_ERROR;
        end else if (valid_in) begin
          if (data_in == IDLE_SYM) begin
            next_state = S_IDLE;
          end
        end else if (gap_cnt == GAP_W'(MAX_GAP - 1)) begin
          next_state = S_ERROR;
        end else begin
          gap_next = gap_cnt + GAP_W'(1);
        end
      end
      S_ERROR: next_state = S_WAIT;
      default: next_state = S_RESET;
    endcase
    if (next_state == S_ERROR) begin
      resync_next = 1'b1;
    end
  end

  // State, counters and all outputs registered on the same edge.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      cur_state <= S_RESET;
      sync_cnt  <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      data_out  <= 8'd0;
      valid_out <= 1'b0;
      link_up   <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
      resync    <= 1'b0;
    end else begin
      cur_state <= next_state;
      sync_cnt  <= sync_next;
      tmo_cnt   <= tmo_next;
      gap_cnt   <= gap_next;
      valid_out <= fwd_c;
      if (fwd_c) begin
        data_out <= data_in;
      end
      link_up   <= (next_state == S_IDLE) || (next_state == S_DATA);
      err       <= (next_state == S_ERROR);
      resync    <= resync_next;
      if ((next_state == S_ERROR) && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sp_link_controller.sv
// Directed + randomized bench for sp_link_controller against a behavioural model.
module tb_sp_link_controller;

  localparam logic [7:0] IDLE = 8'hBC;
  localparam int SYNC_N = 4;
  localparam int TMO_N  = 64;
  localparam int GAP_N  = 16;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b1;
  logic       active = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       link_up;
  logic [2:0] state;
  logic       err;
  logic [7:0] err_count;
  logic       resync;

  int n_assert = 0;
  int n_fail = 0;

  sp_link_controller dut (
    .clk_4f(clk_4f), .reset(reset), .active(active), .valid_in(valid_in),
    .data_in(data_in), .data_out(data_out), .valid_out(valid_out),
    .link_up(link_up), .state(state), .err(err), .err_count(err_count),
    .resync(resync)
  );

  always #5 clk_4f = ~clk_4f;

  // Behavioural model: phase name plus run-lengths of the relevant conditions.
  int         m_phase;      // 0 reset, 1 waiting, 2 idle, 3 data, 4 error
  int         m_high_run;   // consecutive active cycles while waiting
  int         m_wait_age;   // cycles since entering wait / last resync
  int         m_gap_run;    // consecutive empty cycles in data phase
  logic [7:0] m_dout;
  logic       m_vout;
  logic       m_resync;
  int         m_errc;

  function automatic void model_step(input bit r, input bit a, input bit v, input logic [7:0] d);
    int  nxt;
    bit  fwd;
    bit  rs;
    if (r) begin
      m_phase = 0; m_high_run = 0; m_wait_age = 0; m_gap_run = 0;
      m_dout = 8'd0; m_vout = 1'b0; m_resync = 1'b0; m_errc = 0;
      return;
    end
    fwd = (m_phase == 2 || m_phase == 3) && a && v && (d != IDLE);
    rs  = 1'b0;
    nxt = m_phase;
    if (m_phase == 0) nxt = 1;
    else if (m_phase == 1) begin
      m_high_run = a ? m_high_run + 1 : 0;
      m_wait_age = m_wait_age + 1;
      if (m_high_run >= SYNC_N) nxt = 2;
      else if (m_wait_age >= TMO_N) begin
        rs = 1'b1; m_high_run = 0; m_wait_age = 0;
      end
    end else if (m_phase == 2 || m_phase == 3) begin
      if (!a) nxt = 4;
      else if (m_phase == 2) begin
        if (v && d != IDLE) nxt = 3;
      end else if (v) begin
        m_gap_run = 0;
        if (d == IDLE) nxt = 2;
      end else begin
        m_gap_run = m_gap_run + 1;
        if (m_gap_run >= GAP_N) nxt = 4;
      end
    end else nxt = 1;
    if (nxt != m_phase) begin
      m_high_run = 0; m_wait_age = 0; m_gap_run = 0;
    end
    if (nxt == 4) begin
      rs = 1'b1;
      if (m_errc < 255) m_errc = m_errc + 1;
    end
    m_vout = fwd;
    if (fwd) m_dout = d;
    m_resync = rs;
    m_phase = nxt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state",     32'(state),     32'(m_phase));
    check("link_up",   32'(link_up),   32'((m_phase == 2) || (m_phase == 3)));
    check("err",       32'(err),       32'(m_phase == 4));
    check("err_count", 32'(err_count), 32'(m_errc));
    check("resync",    32'(resync),    32'(m_resync));
    check("valid_out", 32'(valid_out), 32'(m_vout));
    check("data_out",  32'(data_out),  32'(m_dout));
  endtask

  task automatic step(input bit r, input bit a, input bit v, input logic [7:0] d);
    reset = r; active = a; valid_in = v; data_in = d;
    @(posedge clk_4f);
    model_step(r, a, v, d);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd0);
  endtask

  task automatic bring_up();
    do_reset();
    for (int i = 0; i < SYNC_N; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
    check("link_up_after_sync", 32'(state), 32'd2);
  endtask

  initial begin
    int pulses;
    m_phase = 0; m_high_run = 0; m_wait_age = 0; m_gap_run = 0;
    m_dout = 8'd0; m_vout = 1'b0; m_resync = 1'b0; m_errc = 0;

    // 1: reset held, then released with active low
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
    check("reset_state", 32'(state), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    check("wait_entry", 32'(state), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h33);
    check("no_fwd_inactive", 32'(valid_out), 32'd0);

    // 2: sync after exactly 4 cycles, then idle stripping
    do_reset();
    for (int i = 0; i < SYNC_N - 1; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'd0);
      check("not_up_yet", 32'(link_up), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 8'd0);
    check("up_at_4", 32'(link_up), 32'd1);
    step(1'b0, 1'b1, 1'b1, 8'hBC); check("seq_s0", 32'(state), 32'd2);
    step(1'b0, 1'b1, 1'b1, 8'hBC); check("seq_s1", 32'(state), 32'd2);
    step(1'b0, 1'b1, 1'b1, 8'h05); check("seq_s2", 32'(state), 32'd3);
    check("fwd_05", 32'({valid_out, data_out}), 32'h105);
    step(1'b0, 1'b1, 1'b1, 8'hA7); check("seq_s3", 32'(state), 32'd3);
    check("fwd_a7", 32'({valid_out, data_out}), 32'h1A7);
    step(1'b0, 1'b1, 1'b1, 8'hBC); check("seq_s4", 32'(state), 32'd2);
    check("idle_strip", 32'({valid_out, data_out}), 32'h0A7);
    step(1'b0, 1'b1, 1'b1, 8'h3C); check("seq_s5", 32'(state), 32'd3);
    check("fwd_3c", 32'({valid_out, data_out}), 32'h13C);

    // 3: loss of sync beats a valid byte
    step(1'b0, 1'b0, 1'b1, 8'h55);
    check("los_err", 32'({err, resync, valid_out}), 32'b110);
    check("los_errcnt", 32'(err_count), 32'd1);
    check("los_dout_held", 32'(data_out), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    check("los_back_wait", 32'({state, err, resync}), 32'b001_0_0);

    // 4: 15-cycle gap tolerated, 16-cycle gap trips
    bring_up();
    step(1'b0, 1'b1, 1'b1, 8'h11);
    for (int i = 0; i < GAP_N - 1; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
    check("gap15_ok", 32'(state), 32'd3);
    step(1'b0, 1'b1, 1'b1, 8'h22);
    for (int i = 0; i < GAP_N; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
    check("gap16_err", 32'({state, err}), 32'b100_1);

    // 5: timeout resync pulses every 64 cycles with active low
    reset = 1'b1; active = 1'b0; valid_in = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    pulses = 0;
    for (int i = 1; i < 200; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'd0);
      check("timeout_pulse", 32'(resync), 32'((i % TMO_N) == 0));
      if (resync) pulses++;
    end
    check("timeout_count", 32'(pulses), 32'd3);
    check("timeout_no_link", 32'(link_up), 32'd0);

    // 6: saturation of err_count, then reset mid data phase
    bring_up();
    for (int k = 0; k < 260; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < SYNC_N + 1; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
    end
    check("err_sat", 32'(err_count), 32'd255);
    step(1'b0, 1'b1, 1'b1, 8'h77);
    check("pre_reset_data", 32'(state), 32'd3);
    step(1'b1, 1'b1, 1'b1, 8'h99);
    check("mid_reset", 32'({state, link_up, valid_out, err, resync, err_count, data_out}),
          32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic a, v;
      logic [7:0] d;
      a = ($urandom_range(0, 19) != 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) == 0) ? IDLE : 8'($urandom);
      if ((i % 300) >= 280) v = 1'b0;
      step(1'b0, a, v, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
